// File: rtl/mem_arbiter_2port.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// It also runs a zeroing sweep after reset and whenever clr is requested.
module mem_arbiter_2port #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  init_busy,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [WIDTH-1:0]      wdata_a,
  input  logic [WIDTH-1:0]      wdata_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic [WIDTH-1:0]      rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  typedef enum logic {INIT, RUN} state_t;
  typedef enum logic {ID_A, ID_B} id_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  id_t                   rr_last;
  logic [ADDR_WIDTH-1:0] cnt;

  assign init_busy = (state == INIT);
  assign rdata     = mem_rdata;

  // On a conflict the requester that was not served last wins.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state == RUN) begin
      if (req_a && (!req_b || rr_last == ID_B))
        gnt_a = 1'b1;
      else if (req_b)
        gnt_b = 1'b1;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == INIT) begin
      mem_we   = 1'b1;
      mem_addr = cnt;
    end else if (gnt_a) begin
      mem_we    = we_a;
      mem_addr  = addr_a;
      mem_wdata = wdata_a;
    end else if (gnt_b) begin
      mem_we    = we_b;
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      cnt      <= '0;
      rr_last  <= ID_B;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= gnt_a & ~we_a;
      rvalid_b <= gnt_b & ~we_b;
      if (gnt_a)
        rr_last <= ID_A;
      else if (gnt_b)
        rr_last <= ID_B;
      case (state)
        INIT: begin
          if (cnt == LAST) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        RUN: begin
          // An access granted alongside clr still completes; only the mode changes.
          if (clr) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Bench for mem_arbiter_2port: memory model, cycle-level reference model,
// and directed scenarios with literal expectations.
module tb_mem_arbiter_2port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       init_busy;
  logic       req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [3:0] addr_a = '0, addr_b = '0;
  logic [7:0] wdata_a = '0, wdata_b = '0;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0] rdata;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter_2port #(.WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .init_busy(init_busy),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory, registered read, write-first.
  logic [7:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      mem_rdata     <= mem_wdata;
    end else begin
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the memory should hold, sweep progress, who wins
  // the next conflict, and which read result is due this cycle.
  logic [7:0] m_mem [16];
  bit         m_init   = 1'b1;
  int         m_idx    = 0;
  bit         m_pref_b = 1'b0;
  bit         p_a = 1'b0, p_b = 1'b0;
  logic [7:0] p_d = '0;
  initial for (int i = 0; i < 16; i++) m_mem[i] = 8'hFF;

  always @(negedge clk) begin
    logic       e_ga, e_gb, e_we;
    logic [3:0] e_addr;
    logic [7:0] e_wd;
    if (rst) begin
      chk("rst_busy", 32'(init_busy), 1);
      chk("rst_gnt_a", 32'(gnt_a), 0);
      chk("rst_gnt_b", 32'(gnt_b), 0);
      chk("rst_mem_we", 32'(mem_we), 1);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_rvalid_a", 32'(rvalid_a), 0);
      chk("rst_rvalid_b", 32'(rvalid_b), 0);
      m_mem[0] = 8'h00;
      m_init = 1'b1; m_idx = 0; m_pref_b = 1'b0; p_a = 1'b0; p_b = 1'b0;
    end else begin
      chk("rvalid_a", 32'(rvalid_a), 32'(p_a));
      chk("rvalid_b", 32'(rvalid_b), 32'(p_b));
      if (p_a || p_b) chk("rdata", 32'(rdata), 32'(p_d));
      e_ga = 1'b0; e_gb = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
      if (m_init) begin
        e_we = 1'b1; e_addr = 4'(m_idx);
      end else begin
        if (req_a && req_b) begin
          e_ga = !m_pref_b; e_gb = m_pref_b;
        end else begin
          e_ga = req_a; e_gb = req_b;
        end
        if (e_ga) begin e_we = we_a; e_addr = addr_a; e_wd = wdata_a; end
        if (e_gb) begin e_we = we_b; e_addr = addr_b; e_wd = wdata_b; end
      end
      chk("init_busy", 32'(init_busy), 32'(m_init));
      chk("gnt_a", 32'(gnt_a), 32'(e_ga));
      chk("gnt_b", 32'(gnt_b), 32'(e_gb));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      p_a = e_ga && !we_a;
      p_b = e_gb && !we_b;
      p_d = m_mem[e_addr];
      if (m_init) begin
        m_mem[m_idx] = 8'h00;
        m_idx++;
        if (m_idx == 16) begin m_init = 1'b0; m_idx = 0; end
      end else begin
        if (e_we) m_mem[e_addr] = e_wd;
        if (e_ga) m_pref_b = 1'b1;
        else if (e_gb) m_pref_b = 1'b0;
        if (clr) begin m_init = 1'b1; m_idx = 0; end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wneg();
    @(negedge clk); #1;
  endtask

  // Issue one access and hold it until granted; returns at edge+1 after the grant.
  task automatic acc(input bit port_b, input bit we, input logic [3:0] a, input logic [7:0] d);
    bit got = 1'b0;
    if (port_b) begin req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d; end
    else        begin req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d; end
    for (int n = 0; n < 20 && !got; n++) begin
      wneg();
      got = port_b ? gnt_b : gnt_a;
    end
    chk("acc_granted", 32'(got), 1);
    cyc();
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (16) cyc();
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Sweep after reset while A is already requesting.
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd0;
    repeat (3) cyc();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wneg();
      chk("sweep_busy", 32'(init_busy), 1);
      chk("sweep_addr", 32'(mem_addr), 32'(i));
      chk("sweep_wdata", 32'(mem_wdata), 0);
      chk("sweep_gnt_a", 32'(gnt_a), 0);
    end
    wneg();
    chk("first_gnt_a", 32'(gnt_a), 1);
    chk("first_busy", 32'(init_busy), 0);
    @(posedge clk); #1;
    req_a = 1'b0;

    // Write then read back through A.
    acc(1'b0, 1'b1, 4'd3, 8'hA5);
    acc(1'b0, 1'b0, 4'd3, 8'h00);
    wneg();
    chk("rd3_rvalid_a", 32'(rvalid_a), 1);
    chk("rd3_rvalid_b", 32'(rvalid_b), 0);
    chk("rd3_rdata", 32'(rdata), 32'hA5);
    cyc();

    // Both requesting reads: alternation starting with A.
    do_reset();
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd2;
    for (int k = 0; k < 4; k++) begin
      wneg();
      chk("alt_gnt_a", 32'(gnt_a), 32'(k % 2 == 0));
      chk("alt_gnt_b", 32'(gnt_b), 32'(k % 2 == 1));
      if (k > 0) chk("alt_rvalid_a", 32'(rvalid_a), 32'(k % 2 == 1));
      cyc();
    end
    req_a = 1'b0; req_b = 1'b0;
    wneg();
    chk("alt_last_rvalid_b", 32'(rvalid_b), 1);
    cyc();

    // clr reruns the sweep; B gets nothing until it ends.
    acc(1'b0, 1'b1, 4'd7, 8'h3C);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd7;
    for (int i = 0; i < 16; i++) begin
      wneg();
      chk("clr_gnt_b", 32'(gnt_b), 0);
      chk("clr_addr", 32'(mem_addr), 32'(i));
      cyc();
    end
    wneg();
    chk("clr_post_gnt_b", 32'(gnt_b), 1);
    cyc();
    req_b = 1'b0;
    wneg();
    chk("clr_rvalid_b", 32'(rvalid_b), 1);
    chk("clr_rdata", 32'(rdata), 32'h00);
    cyc();

    // Reset right after a read grant drops the pending rvalid.
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd5;
    wneg();
    chk("rr5_gnt_a", 32'(gnt_a), 1);
    @(posedge clk); #1;
    rst = 1'b1; req_a = 1'b0;
    wneg();
    chk("rr5_rvalid_a", 32'(rvalid_a), 0);
    chk("rr5_busy", 32'(init_busy), 1);
    chk("rr5_addr", 32'(mem_addr), 0);
    cyc();
    rst = 1'b0;
    repeat (16) cyc();

    // B alone, then A joins and wins first.
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd4;
    for (int k = 0; k < 3; k++) begin
      wneg();
      chk("bonly_gnt_b", 32'(gnt_b), 1);
      chk("bonly_gnt_a", 32'(gnt_a), 0);
      cyc();
    end
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd2;
    wneg();
    chk("join_gnt_a", 32'(gnt_a), 1);
    chk("join_gnt_b", 32'(gnt_b), 0);
    cyc();
    wneg();
    chk("join2_gnt_b", 32'(gnt_b), 1);
    cyc();
    req_a = 1'b0; req_b = 1'b0;

    // Read immediately after a write to the same address.
    acc(1'b1, 1'b1, 4'd9, 8'h5E);
    acc(1'b0, 1'b0, 4'd9, 8'h00);
    wneg();
    chk("raw_rvalid_a", 32'(rvalid_a), 1);
    chk("raw_rdata", 32'(rdata), 32'h5E);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
